fan_mode_controller: RTL

Fan operating-mode controller and time-base generator for the fan controller datapath. It converts single-cycle button pulses into the 2-bit fan `state` consumed by the battery manager. It generates the `timer_100ms`/`timer_200ms` strobes that the battery manager uses for charge and discharge steps, and forces the fan off when `battery_empty` is raised. It also provides a 0–90 s auto-off countdown.

---
 rtl/fan_mode_controller.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fan_mode_controller.sv
// Fan operating-mode controller: turns button pulses into the fan state,
// generates the 100 ms / 200 ms strobes and runs the 0-90 s auto-off timer.
module fan_mode_controller #(
  parameter int TICK_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_power,
  input  logic       btn_speed,
  input  logic       btn_timer,
  input  logic       battery_empty,
  output logic [1:0] state,
  output logic       timer_100ms,
  output logic       timer_200ms,
  output logic [6:0] countdown,
  output logic       timer_active
);

  // state   | meaning
  // ST_OFF  | fan stopped, countdown held at 0
  // ST_LOW  | fan running at low speed
  // ST_HIGH | fan running at high speed
  localparam logic [1:0] ST_OFF  = 2'b00;
  localparam logic [1:0] ST_LOW  = 2'b01;
  localparam logic [1:0] ST_HIGH = 2'b10;

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          t100_q, t100_d;
  logic          t200_q, t200_d;
  logic          phase_q, phase_d;
  logic [3:0]    sec_div_q, sec_div_d;
  logic          sec_event;
  logic [1:0]    state_q, state_d;
  logic [6:0]    cd_q, cd_d;
  logic          active_q, active_d;

  // Next timer setting: below 10 -> 10, else up to the next multiple of 10;
  // 90 and above cancels the timer.
  function automatic logic [6:0] timer_step(input logic [6:0] cd);
    logic [6:0] r;
    r = 7'd0;
    for (int i = 9; i >= 1; i--) begin
      if (cd < 7'(i * 10)) r = 7'(i * 10);
    end
    return r;
  endfunction

  // Time base: free-running tick counter, strobes and one-second divider.
  // The phase used for the 200 ms strobe already includes a toggle from a
  // strobe that is high this cycle, so back-to-back strobes also pair up.
  always_comb begin
    tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
    t100_d     = (tick_cnt_q == TICK_LAST);
    phase_d    = phase_q ^ t100_q;
    t200_d     = t100_d & phase_d;
    sec_div_d  = sec_div_q;
    if (t100_q) sec_div_d = (sec_div_q == 4'd9) ? 4'd0 : sec_div_q + 4'd1;
    sec_event  = t100_q && (sec_div_q == 4'd9);
  end

  // Mode FSM and countdown, one event per cycle in priority order.
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    if (state_q != ST_OFF && battery_empty) begin
      state_d = ST_OFF;
      cd_d    = 7'd0;
    end else if (btn_power) begin
      if (state_q == ST_OFF) begin
        if (!battery_empty) state_d = ST_LOW;
        cd_d = 7'd0;
      end else begin
        state_d = ST_OFF;
        cd_d    = 7'd0;
      end
    end else if (state_q == ST_OFF) begin
      cd_d = 7'd0;
    end else if (sec_event && cd_q == 7'd1) begin
      state_d = ST_OFF;
      cd_d    = 7'd0;
    end else begin
      if (btn_speed) state_d = (state_q == ST_LOW) ? ST_HIGH : ST_LOW;
      // A timer press replaces the decrement that would happen this cycle.
      if (!btn_speed && btn_timer) cd_d = timer_step(cd_q);
      else if (sec_event && cd_q != 7'd0) cd_d = cd_q - 7'd1;
    end
    active_d = (cd_d != 7'd0);
  end

  // Registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      t100_q     <= 1'b0;
      t200_q     <= 1'b0;
      phase_q    <= 1'b0;
      sec_div_q  <= 4'd0;
      state_q    <= ST_OFF;
      cd_q       <= 7'd0;
      active_q   <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      t100_q     <= t100_d;
      t200_q     <= t200_d;
      phase_q    <= phase_d;
      sec_div_q  <= sec_div_d;
      state_q    <= state_d;
      cd_q       <= cd_d;
      active_q   <= active_d;
    end
  end

  assign state        = state_q;
  assign timer_100ms  = t100_q;
  assign timer_200ms  = t200_q;
  assign countdown    = cd_q;
  assign timer_active = active_q;

endmodule
